// File: rtl/bcd_seq_conv.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seq_conv
// Description : Signed binary to sign + packed BCD, double-dabble, 1 bit/clk
// Revision    : 1.0
// ============================================================================
module bcd_seq_conv #(
  parameter int W = 14,
  parameter int D = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic           neg
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t         state;
  logic [W-1:0]   mag;
  logic           sgn;
  logic [4*D-1:0] scratch;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   mag_abs;
  logic [4*D-1:0] adj;
  logic [4*D-1:0] scratch_next;
  logic           top_carry_unused;

  // W-bit unsigned magnitude; -2^(W-1) maps onto itself, which is its true value
  assign mag_abs = bin[W-1] ? (~bin + {{(W-1){1'b0}}, 1'b1}) : bin;

  for (genvar i = 0; i < D; i++) begin : g_adj
    assign adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ?
                           (scratch[4*i +: 4] + 4'd3) : scratch[4*i +: 4];
  end

  // With 10^D > 2^(W-1) the top digit never carries out, so this bit is always 0
  assign top_carry_unused = adj[4*D-1];
  assign scratch_next     = {adj[4*D-2:0], mag[W-1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mag     <= '0;
      sgn     <= 1'b0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      neg     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ena) begin
        case (state)
          IDLE: begin
            if (start) begin
              mag     <= mag_abs;
              sgn     <= bin[W-1];
              scratch <= '0;
              cnt     <= '0;
              busy    <= 1'b1;
              state   <= CONV;
            end
          end
          CONV: begin
            scratch <= scratch_next;
            mag     <= {mag[W-2:0], 1'b0};
            cnt     <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              bcd   <= scratch_next;
              neg   <= sgn;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_conv.sv
`default_nettype none
// Scoreboard bench for bcd_seq_conv: driver pushes expected results, a
// negedge monitor pops them whenever done is seen.
module tb_bcd_seq_conv;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        neg;

  bcd_seq_conv #(.W(14), .D(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .neg(neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic        neg;
    int          due;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal reference: absolute value, then digits by repeated division
  function automatic exp_t model(input logic [13:0] v);
    exp_t e;
    int   s;
    int   m;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    e.bcd = '0;
    for (int i = 0; i < 4; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    e.neg = (s < 0);
    e.due = 0;
    e.lat = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("bcd", {16'd0, bcd}, {16'd0, e.bcd});
          chk("neg", {31'd0, neg}, {31'd0, e.neg});
          chk("done_cycle", cyc, e.due);
          chk("busy_cycles", busy_cnt, e.lat);
        end
        busy_cnt = 0;
      end
    end
  end

  // Called at a negedge with the DUT idle and ena high; returns at the next negedge
  task automatic accept(input int v, input int lat);
    exp_t  e;
    logic [13:0] vb;
    vb    = v[13:0];
    bin   = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    e     = model(vb);
    e.due = cyc + lat;
    e.lat = lat;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_stall(input int v, input int at, input int len);
    accept(v, 14 + len);
    repeat (at) @(negedge clk);
    if (len > 0) begin
      ena = 1'b0;
      repeat (len) @(negedge clk);
      ena = 1'b1;
    end
    wait_done();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bcd",  {16'd0, bcd},  32'd0);
    chk("rst_neg",  {31'd0, neg},  32'd0);
    rst = 1'b1;
    @(negedge clk);

    accept(1234, 14);  wait_done();
    accept(-8192, 14); wait_done();
    accept(8191, 14);  wait_done();
    accept(0, 14);     wait_done();
    accept(-1, 14);    wait_done();

    // Starts and input changes during CONV must be ignored
    accept(-50, 14);
    repeat (2) @(negedge clk);
    bin = 14'd999; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done();
    accept(999, 14);   wait_done();

    run_stall(4321, 4, 5);

    // Abort by asynchronous reset mid-conversion
    bin = 14'd1234; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_bcd",  {16'd0, bcd},  32'd0);
    chk("abort_neg",  {31'd0, neg},  32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    accept(7, 14);     wait_done();

    // Random values, random stalls, back-to-back starts and idle ena drops
    for (int k = 0; k < 40; k++) begin
      int v;
      int at;
      int len;
      v   = int'($urandom_range(0, 16383)) - 8192;
      at  = int'($urandom_range(0, 10));
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_stall(v, at, len);
      if ($urandom_range(0, 3) == 0) begin
        ena = 1'b0;
        repeat (2) @(negedge clk);
        ena = 1'b1;
      end
    end

    repeat (20) @(negedge clk);
    chk("queue_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
